// File: rtl/conv_viterbi_dec.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) convolutional code.
// It runs a 4-state add-compare-select with register-exchange survivors.
// One decoded bit is produced per accepted symbol once the survivor depth is full.
module conv_viterbi_dec #(
    parameter int TB_DEPTH = 16,
    parameter int METRIC_W = 6,
    parameter int INIT_BIG = 16
) (
    input  logic                clk20M_sig,
    input  logic                reset_sig,
    input  logic [1:0]          encode_sig,
    input  logic                encode_valid_sig,
    output logic                decode_sig,
    output logic                decode_valid_sig,
    output logic [METRIC_W-1:0] best_metric_sig
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [METRIC_W:0] SAT_MAX = {1'b0, {METRIC_W{1'b1}}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TB_DEPTH);

    logic [METRIC_W-1:0] pm [4];
    logic [TB_DEPTH-1:0] surv [4];
    logic [CNT_W-1:0]    fill_cnt;
    logic                accepted_d;

    logic [METRIC_W:0]   cand0 [4];
    logic [METRIC_W:0]   cand1 [4];
    logic                take_p1 [4];
    logic [METRIC_W:0]   raw [4];
    logic [METRIC_W:0]   diff [4];
    logic [METRIC_W:0]   raw_min;
    logic [METRIC_W-1:0] pm_next [4];
    logic [TB_DEPTH-1:0] surv_next [4];
    logic [1:0]          best_idx;

    // Hamming distance between the received symbol and the encoder output for
    // predecessor state p = {s1,s0} driven by input bit u.
    function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic u,
                                                 input logic [1:0] sym);
        logic g0;
        logic g1;
        g0 = u ^ p[0] ^ p[1];
        g1 = u ^ p[1];
        return {1'b0, g0 ^ sym[1]} + {1'b0, g1 ^ sym[0]};
    endfunction

    // Add-compare-select for every next state, then normalize against the minimum and saturate.
    always_comb begin
        raw_min = '1;
        for (int ns = 0; ns < 4; ns++) begin
            cand0[ns] = {1'b0, pm[ns >> 1]}
                      + {{(METRIC_W-1){1'b0}}, branch_metric(2'(ns >> 1), 1'(ns), encode_sig)};
            cand1[ns] = {1'b0, pm[2 + (ns >> 1)]}
                      + {{(METRIC_W-1){1'b0}}, branch_metric(2'(2 + (ns >> 1)), 1'(ns), encode_sig)};
            take_p1[ns] = (cand1[ns] < cand0[ns]);
            raw[ns] = take_p1[ns] ? cand1[ns] : cand0[ns];
            surv_next[ns] = take_p1[ns]
                          ? {surv[2 + (ns >> 1)][TB_DEPTH-2:0], 1'(ns)}
                          : {surv[ns >> 1][TB_DEPTH-2:0], 1'(ns)};
            if (raw[ns] < raw_min) begin
                raw_min = raw[ns];
            end
        end
        for (int ns = 0; ns < 4; ns++) begin
            diff[ns] = raw[ns] - raw_min;
            pm_next[ns] = (diff[ns] > SAT_MAX) ? SAT_MAX[METRIC_W-1:0] : diff[ns][METRIC_W-1:0];
        end
    end

    // Pick the state with the smallest registered metric; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (pm[i] < pm[best_idx]) begin
                best_idx = 2'(i);
            end
        end
    end

    // Path metrics, survivors and fill counter advance only on accepted symbols.
    always_ff @(posedge clk20M_sig) begin
        if (reset_sig) begin
            for (int i = 0; i < 4; i++) begin
                pm[i]   <= (i == 0) ? '0 : METRIC_W'(INIT_BIG);
                surv[i] <= '0;
            end
            fill_cnt   <= '0;
            accepted_d <= 1'b0;
        end else begin
            accepted_d <= encode_valid_sig;
            if (encode_valid_sig) begin
                for (int i = 0; i < 4; i++) begin
                    pm[i]   <= pm_next[i];
                    surv[i] <= surv_next[i];
                end
                if (fill_cnt != FULL_CNT) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

    // Output stage: one edge after the ACS update, read the oldest bit of the best survivor.
    always_ff @(posedge clk20M_sig) begin
        if (reset_sig) begin
            decode_sig       <= 1'b0;
            decode_valid_sig <= 1'b0;
            best_metric_sig  <= '0;
        end else begin
            decode_valid_sig <= accepted_d && (fill_cnt == FULL_CNT);
            if (accepted_d) begin
                decode_sig      <= surv[best_idx][TB_DEPTH-1];
                best_metric_sig <= pm[best_idx];
            end
        end
    end

endmodule

// File: tb/tb_conv_viterbi_dec.sv
// Self-checking bench for conv_viterbi_dec: directed encoder streams with a bench-side
// reference of the expected decode timing and decoded bits.
module tb_conv_viterbi_dec;

    localparam int DEPTH = 16;
    localparam int MW    = 6;

    logic          clk20M_sig = 1'b0;
    logic          reset_sig;
    logic [1:0]    encode_sig;
    logic          encode_valid_sig;
    logic          decode_sig;
    logic          decode_valid_sig;
    logic [MW-1:0] best_metric_sig;

    int   test_count = 0;
    int   fail_count = 0;
    logic started = 1'b0;

    logic [1:0] enc_state;
    logic       cur_bit;

    // Reference timing model: symbol n is recorded at its accept edge, its decode appears one edge later.
    bit   hist [8192];
    int   n;
    logic acc1;
    logic bit1;
    logic want_valid;
    logic exp_bit;

    conv_viterbi_dec #(.TB_DEPTH(DEPTH), .METRIC_W(MW), .INIT_BIG(16)) dut (
        .clk20M_sig       (clk20M_sig),
        .reset_sig        (reset_sig),
        .encode_sig       (encode_sig),
        .encode_valid_sig (encode_valid_sig),
        .decode_sig       (decode_sig),
        .decode_valid_sig (decode_valid_sig),
        .best_metric_sig  (best_metric_sig)
    );

    // 20 MHz clock.
    always #25 clk20M_sig = ~clk20M_sig;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model of when a decoded bit is due and which input bit it must be.
    always @(posedge clk20M_sig) begin
        if (reset_sig) begin
            n          <= 0;
            acc1       <= 1'b0;
            bit1       <= 1'b0;
            want_valid <= 1'b0;
            exp_bit    <= 1'b0;
        end else begin
            want_valid <= acc1;
            if (acc1) exp_bit <= bit1;
            acc1 <= 1'b0;
            if (encode_valid_sig) begin
                hist[n] <= cur_bit;
                n <= n + 1;
                if (n >= DEPTH - 1) begin
                    acc1 <= 1'b1;
                    bit1 <= hist[n - (DEPTH - 1)];
                end
            end
        end
    end

    // Every cycle: strobe timing, decoded/held bit, and the normalized best metric (always zero
    // since normalization pins the minimum metric to zero, even after a corrected error).
    always @(negedge clk20M_sig) begin
        if (started) begin
            checkOutput("decode_valid", {31'd0, decode_valid_sig}, {31'd0, want_valid});
            checkOutput("decode_bit", {31'd0, decode_sig}, {31'd0, exp_bit});
            checkOutput("best_metric", {26'd0, best_metric_sig}, 32'd0);
        end
    end

    // Encode one data bit, optionally corrupt it, present it for one cycle, then idle for gap cycles.
    task automatic applyStimulus(input logic u, input logic [1:0] err, input int gap);
        logic [1:0] sym;
        sym = {u ^ enc_state[0] ^ enc_state[1], u ^ enc_state[1]} ^ err;
        enc_state = {enc_state[0], u};
        encode_sig = sym;
        encode_valid_sig = 1'b1;
        cur_bit = u;
        @(negedge clk20M_sig);
        encode_valid_sig = 1'b0;
        repeat (gap) @(negedge clk20M_sig);
    endtask

    // One-cycle reset with a symbol strobe held high to show it is ignored.
    task automatic resetDut();
        reset_sig = 1'b1;
        encode_valid_sig = 1'b1;
        encode_sig = 2'b11;
        @(negedge clk20M_sig);
        reset_sig = 1'b0;
        encode_valid_sig = 1'b0;
        encode_sig = 2'b00;
        enc_state = 2'b00;
        started = 1'b1;
        checkOutput("reset_valid", {31'd0, decode_valid_sig}, 32'd0);
        checkOutput("reset_bit", {31'd0, decode_sig}, 32'd0);
        checkOutput("reset_metric", {26'd0, best_metric_sig}, 32'd0);
    endtask

    // Data 1,0,1,1,0,0 followed by 16 zeros -> symbols 11,10,00,01,01,11,00...
    task automatic runPattern(input int gap, input int err_idx);
        logic [5:0] pat;
        logic u;
        pat = 6'b001101;
        for (int i = 0; i < 22; i++) begin
            u = (i < 6) ? pat[i] : 1'b0;
            applyStimulus(u, (i == err_idx) ? 2'b01 : 2'b00, gap);
        end
        repeat (3) @(negedge clk20M_sig);
    endtask

    initial begin
        reset_sig = 1'b1;
        encode_valid_sig = 1'b0;
        encode_sig = 2'b00;
        cur_bit = 1'b0;
        enc_state = 2'b00;
        @(negedge clk20M_sig);

        $display("[TB] all-zero stream");
        resetDut();
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 2'b00, 0);
        repeat (3) @(negedge clk20M_sig);

        $display("[TB] pattern 101100");
        resetDut();
        runPattern(0, -1);

        $display("[TB] pattern with a flipped bit in symbol 3");
        resetDut();
        runPattern(0, 3);

        $display("[TB] pattern with 3 idle cycles between symbols");
        resetDut();
        runPattern(3, -1);

        $display("[TB] reset mid-stream then pattern");
        resetDut();
        for (int i = 0; i < 10; i++) applyStimulus(1'($urandom_range(1)), 2'b00, 0);
        resetDut();
        runPattern(0, -1);

        $display("[TB] long random stream");
        resetDut();
        for (int i = 0; i < 4096; i++) applyStimulus(1'($urandom_range(1)), 2'b00, 0);
        repeat (3) @(negedge clk20M_sig);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
